// File: rtl/hello_pkg.sv
// Shared constants for the HELLO scroller: character codes, the fixed message,
// controller state type and the display-code builder.
package hello_pkg;

   localparam logic [2:0] CH_H     = 3'd0;
   localparam logic [2:0] CH_E     = 3'd1;
   localparam logic [2:0] CH_L     = 3'd2;
   localparam logic [2:0] CH_O     = 3'd3;
   localparam logic [2:0] CH_BLANK = 3'd7;

   // MSG[0] is the first character shown on the leftmost display at offset 0.
   localparam logic [7:0][2:0] MSG = {CH_BLANK, CH_BLANK, CH_BLANK, CH_O,
                                      CH_L, CH_L, CH_E, CH_H};

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic [23:0] codes_for(input logic [2:0] pos);
      logic [23:0] r;
      r = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         r[3*k +: 3] = MSG[3'(7 - k + pos)];
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Scroll-rate prescaler: counts 0..TICK_DIV-1 while enabled, wraps at terminal count.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == W'(TICK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Rotating "HELLO" message controller driving eight HELO display code slots.
// Optional HELLO_SCROLL_REVERSE_EN adds a Dir input for backward scrolling.
module hello_scroll_ctrl
   import hello_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Run,
   input  logic        Step,
`ifdef HELLO_SCROLL_REVERSE_EN
   input  logic        Dir,
`endif
   output logic [23:0] Codes,
   output logic [2:0]  Pos,
   output logic        Tick
);

   state_e      state_q, state_d;
   logic [2:0]  pos_q, pos_d;
   logic [23:0] codes_q, codes_d;
   logic        tick_q, tick_d;
   logic        step_q, step_d;
   logic        tc;
   logic        advance;
   logic [2:0]  delta;

   // Prescaler follows the next state so RUN entry counts from its first cycle
   // and every STOP cycle holds it cleared.
   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk(Clk),
      .rst(Reset),
      .clr(state_d == ST_STOP),
      .en (state_d == ST_RUN),
      .tc (tc)
   );

`ifdef HELLO_SCROLL_REVERSE_EN
   assign delta = Dir ? 3'd7 : 3'd1;
`else
   assign delta = 3'd1;
`endif

   always_comb begin
      state_d = Run ? ST_RUN : ST_STOP;
      step_d  = Step;
      advance = 1'b0;
      if (state_d == ST_RUN) begin
         advance = tc;
      end else begin
         advance = Step & ~step_q;
      end
      pos_d   = advance ? pos_q + delta : pos_q;
      tick_d  = advance;
      codes_d = codes_for(pos_q);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_STOP;
         pos_q   <= '0;
         tick_q  <= 1'b0;
         step_q  <= 1'b0;
         codes_q <= codes_for(3'd0);
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         tick_q  <= tick_d;
         step_q  <= step_d;
         codes_q <= codes_d;
      end
   end

   assign Codes = codes_q;
   assign Pos   = pos_q;
   assign Tick  = tick_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Self-checking bench for hello_scroll_ctrl (TICK_DIV=4): directed scenarios plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_hello_scroll_ctrl;

   localparam int unsigned TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst, run, step, dir;
   logic [23:0] codes;
   logic [2:0]  pos;
   logic        tick;

   int checks = 0;
   int errors = 0;

   int unsigned m_pos;
   int unsigned m_run_cycles;
   bit          m_prev_step;
   bit          m_tick;
   logic [23:0] m_codes;

   int unsigned msg [8] = '{0, 1, 2, 2, 3, 7, 7, 7};

   logic [23:0] reset_codes;
   logic [23:0] pos1_codes;
   logic [23:0] pos7_codes;

   hello_scroll_ctrl #(
      .TICK_DIV(TICK_DIV)
   ) dut (
      .Clk  (clk),
      .Reset(rst),
      .Run  (run),
      .Step (step),
`ifdef HELLO_SCROLL_REVERSE_EN
      .Dir  (dir),
`endif
      .Codes(codes),
      .Pos  (pos),
      .Tick (tick)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pattern(input int unsigned p);
      logic [23:0] r;
      r = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         r[3*k +: 3] = 3'(msg[(7 - k + p) % 8]);
      end
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, step the model, compare all outputs.
   task automatic cycle(input bit r, input bit ru, input bit st, input bit d);
      bit adv;
      bit eff_dir;
      @(negedge clk);
      rst  = r;
      run  = ru;
      step = st;
      dir  = d;
      @(posedge clk);
`ifdef HELLO_SCROLL_REVERSE_EN
      eff_dir = d;
`else
      eff_dir = 1'b0;
`endif
      if (r) begin
         m_pos        = 0;
         m_run_cycles = 0;
         m_prev_step  = 1'b0;
         m_tick       = 1'b0;
         m_codes      = pattern(0);
      end else begin
         m_codes = pattern(m_pos);
         adv     = 1'b0;
         if (ru) begin
            m_run_cycles++;
            if (m_run_cycles == TICK_DIV) begin
               adv          = 1'b1;
               m_run_cycles = 0;
            end
         end else begin
            m_run_cycles = 0;
            if (st && !m_prev_step) adv = 1'b1;
         end
         m_prev_step = st;
         if (adv) m_pos = eff_dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
         m_tick = adv;
      end
      #1;
      check_eq("pos", 32'(pos), 32'(m_pos));
      check_eq("tick", 32'(tick), 32'(m_tick));
      check_eq("codes", 32'(codes), 32'(m_codes));
   endtask

   initial begin
      rst  = 1'b1;
      run  = 1'b0;
      step = 1'b0;
      dir  = 1'b0;
      reset_codes = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7};
      pos1_codes  = {3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7, 3'd0};
      pos7_codes  = {3'd7, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7};

      // Reset state
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      check_eq("rst_pos", 32'(pos), 32'd0);
      check_eq("rst_tick", 32'(tick), 32'd0);
      check_eq("rst_codes", 32'(codes), 32'(reset_codes));

      // Auto-scroll: ticks at run cycles 4, 8, 12
      for (int i = 1; i <= 12; i++) begin
         cycle(0, 1, 0, 0);
         check_eq("run_tick", 32'(tick), (i % 4 == 0) ? 32'd1 : 32'd0);
         if (i % 4 == 0) check_eq("run_pos", 32'(pos), 32'(i / 4));
         if (i == 5) check_eq("pos1_codes", 32'(codes), 32'(pos1_codes));
      end

      // Full wrap over 32 run cycles
      cycle(1, 0, 0, 0);
      for (int i = 1; i <= 32; i++) begin
         cycle(0, 1, 0, 0);
         if (i % 4 == 0) check_eq("wrap_pos", 32'(pos), 32'((i / 4) % 8));
      end
      cycle(0, 0, 0, 0);
      check_eq("wrap_codes", 32'(codes), 32'(reset_codes));

      // Manual step: held high once, then two pulses
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 1, 0);
         check_eq("held_pos", 32'(pos), 32'd1);
      end
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      check_eq("pulse1_pos", 32'(pos), 32'd2);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      check_eq("pulse2_pos", 32'(pos), 32'd3);
      cycle(0, 0, 0, 0);

      // Step ignored while running
      cycle(0, 1, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      check_eq("run_step_ign", 32'(pos), 32'd3);

      // Reset mid-count with Run still high
      cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      check_eq("midrst_pos", 32'(pos), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 1, 0, 0);
         check_eq("midrst_tick", 32'(tick), (i == 4) ? 32'd1 : 32'd0);
      end

      // Terminal count coinciding with Run=0 must not advance
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
      check_eq("tc_stop_pos", 32'(pos), 32'd0);

`ifdef HELLO_SCROLL_REVERSE_EN
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 1);
      check_eq("rev_pos", 32'(pos), 32'd7);
      cycle(0, 0, 0, 1);
      check_eq("rev_codes", 32'(codes), 32'(pos7_codes));
`endif

      // Randomized traffic against the model
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 3) != 0) ^ ((i / 200) % 2 == 1),
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
